karat_mult_recursive: RTL and testbench
=======================================

// Module: karat_mult_recursive
// PURPOSE
//   Unsigned wI x wI -> 2*wI multiplier using nSTAGE levels of recursive
//   Karatsuba decomposition, with native '*' multipliers at the leaves.
//   Operates as a single-job engine: capture operands, compute, pulse o_finish.
//   Used as the wide field-multiply core feeding the MSM datapath.
// PARAMETERS
//   wI      1024  operand width in bits (any value >= 2; odd splits use ceil)
//   nSTAGE  5     Karatsuba recursion depth; 0 = single native multiplier
// PORTS
//   clk       in   1     clock, all state on rising edge
//   rst       in   1     asynchronous, active-high reset
//   i_enable  in   1     start request; sampled only while idle
//   iX        in   wI    operand X, unsigned
//   iY        in   wI    operand Y, unsigned
//   oO        out  2*wI  product X*Y, held until the next completion
//   o_finish  out  1     one-cycle pulse: oO is valid and updated this cycle
// BEHAVIOUR
//   - Clocking/reset: one clock; reset is asynchronous and active-high.
//   - Reset values: oO=0, o_finish=0, internal busy=0, all pipeline regs=0.
//   - States: IDLE -> BUSY -> (completion) -> IDLE.
//   - IDLE:
//     - Rising edge with i_enable=1 captures iX/iY into operand regs (edge k).
//     - The engine then goes BUSY.
//   - BUSY: ignores i_enable/iX/iY; a counter runs LAT = 2*nSTAGE+1 cycles.
//   - Completion:
//     - At edge k+LAT, oO loads the full product and o_finish=1 for exactly
//       one cycle; the engine is IDLE again in that same cycle.
//     - Back-to-back: if i_enable=1 at edge k+LAT+1, new operands are captured
//       there. Steady-state period with i_enable held high = LAT+1 cycles.
//   - i_enable dropping while BUSY does not abort; the job completes normally.
//   - Reset mid-operation: the job is abandoned, o_finish stays 0, oO returns
//     to 0, and nothing from the abandoned job is emitted later.
//   - Recursion, node width w, h = ceil(w/2):
//     - Split operands: X = Xh*2^h + Xl, Y = Yh*2^h + Yl.
//     - z2 = Xh*Yh; z0 = Xl*Yl; z1 = (Xh+Xl)*(Yh+Yl) - z2 - z0.
//     - The sums are h+1 bits wide, so the middle child has width h+1.
//     - Result = z2<<2h + z1<<h + z0, truncated to 2w bits (exact).
//     - Depth d < nSTAGE: register split/pre-add sums, recurse 3 children, then
//       register the combine (2 cycles per level).
//     - Depth nSTAGE: leaf = one registered native multiply (1 cycle).
//   - Implement the recursion with a self-instantiating parameterised submodule
//     or generate.
//   - Arithmetic is unsigned and exact for all inputs. No overflow or
//     saturation paths exist.
//   - oO must equal iX*iY (values at capture) bit-exactly for any wI/nSTAGE.
// TESTING
//   - Reset: rst=1 asynchronously mid-cycle -> oO=0, o_finish=0 immediately.
//     Hold 2 cycles; no o_finish pulse occurs.
//   - Zero/identity: iX=0,iY=random -> oO=0. iX=1,iY=Y -> oO=Y. Each pulse lands
//     exactly 11 cycles after capture (wI=1024, nSTAGE=5).
//   - Worst-case carries: iX=iY=2^1024-1 -> oO = 2^2048 - 2^1025 + 1.
//     Also iX=2^1023, iY=2^1023 -> oO=2^2046.
//   - Streaming: hold i_enable=1 and re-randomise iX/iY after each o_finish.
//     Run >=1000 jobs; every result must equal the reference product.
//     o_finish period is exactly 12 cycles.
//   - Robustness:
//     - Drop i_enable mid-job -> that job still completes; no new capture.
//     - Assert rst mid-job -> no pulse, oO=0.
//     - After release, a new job completes correctly.
//   - Parameter sweep: (wI,nSTAGE) = (8,0),(17,2),(64,3),(1024,5).
//     Random operands match reference; latency = 2*nSTAGE+1.

Source files
------------

// File: rtl/karat_mult_recursive.sv
// Recursive Karatsuba multiplier: one job at a time, captures operands on a
// start request, runs a fixed-latency recursive pipeline and pulses o_finish.

// One recursion node. STAGES levels remain below this node; STAGES == 0 is a
// native multiply. REG_OUT selects whether the final combine (or leaf product)
// is registered here or left to the parent.
module karat_node #(
  parameter int DATA_W  = 8,
  parameter int STAGES  = 0,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);
  localparam int PW = 2 * DATA_W;

  generate
    if (STAGES == 0) begin : g_leaf
      logic [PW-1:0] prod_c;
      assign prod_c = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

      if (REG_OUT) begin : g_reg
        logic [PW-1:0] prod_p0;
        // Leaf product register
        always_ff @(posedge clk or posedge rst) begin
          if (rst) prod_p0 <= '0;
          else     prod_p0 <= prod_c;
        end
        assign p = prod_p0;
      end else begin : g_comb
        assign p = prod_c;
      end
    end else begin : g_split
      // Halves are H bits each; odd widths are zero-padded at the top so the
      // high half never collapses to zero width.
      localparam int H = (DATA_W + 1) / 2;

      logic [2*H-1:0] a_pad, b_pad;
      logic [H-1:0]   xl_p0, xh_p0, yl_p0, yh_p0;
      logic [H:0]     xs_p0, ys_p0;
      logic [2*H-1:0] z2, z0;
      logic [2*H+1:0] zm;
      logic [PW-1:0]  comb_c;

      assign a_pad = (2*H)'(a);
      assign b_pad = (2*H)'(b);

      // Stage p0: split halves and pre-add sums for the middle product
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xl_p0 <= '0;
          xh_p0 <= '0;
          yl_p0 <= '0;
          yh_p0 <= '0;
          xs_p0 <= '0;
          ys_p0 <= '0;
        end else begin
          xl_p0 <= a_pad[H-1:0];
          xh_p0 <= a_pad[2*H-1:H];
          yl_p0 <= b_pad[H-1:0];
          yh_p0 <= b_pad[2*H-1:H];
          xs_p0 <= {1'b0, a_pad[H-1:0]} + {1'b0, a_pad[2*H-1:H]};
          ys_p0 <= {1'b0, b_pad[H-1:0]} + {1'b0, b_pad[2*H-1:H]};
        end
      end

      karat_node #(.DATA_W(H), .STAGES(STAGES-1), .REG_OUT(1'b1)) u_hi (
        .clk(clk), .rst(rst), .a(xh_p0), .b(yh_p0), .p(z2)
      );
      karat_node #(.DATA_W(H), .STAGES(STAGES-1), .REG_OUT(1'b1)) u_lo (
        .clk(clk), .rst(rst), .a(xl_p0), .b(yl_p0), .p(z0)
      );
      karat_node #(.DATA_W(H+1), .STAGES(STAGES-1), .REG_OUT(1'b1)) u_mid (
        .clk(clk), .rst(rst), .a(xs_p0), .b(ys_p0), .p(zm)
      );

      // Combine modulo 2^PW; the true product fits, so wrap-around in the
      // intermediate terms cancels exactly.
      assign comb_c = (PW'(z2) << (2*H))
                    + ((PW'(zm) - PW'(z2) - PW'(z0)) << H)
                    + PW'(z0);

      if (REG_OUT) begin : g_reg
        logic [PW-1:0] p_p1;
        // Stage p1: combined product register
        always_ff @(posedge clk or posedge rst) begin
          if (rst) p_p1 <= '0;
          else     p_p1 <= comb_c;
        end
        assign p = p_p1;
      end else begin : g_comb
        assign p = comb_c;
      end
    end
  endgenerate
endmodule

module karat_mult_recursive #(
  parameter int wI     = 1024,
  parameter int nSTAGE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [wI-1:0]     iX,
  input  logic [wI-1:0]     iY,
  output logic [2*wI-1:0]   oO,
  output logic              o_finish
);
  localparam int LAT   = 2 * nSTAGE + 1;
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture, done;
  logic [wI-1:0]    x_p0, y_p0;
  logic [2*wI-1:0]  prod;

  // Control state and latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: counter runs LAT busy cycles, then returns to idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (i_enable) begin
          state_nxt = S_BUSY;
          cnt_nxt   = '0;
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(LAT - 1)) state_nxt = S_IDLE;
        else                        cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes: operand capture while idle, completion on the last busy cycle
  always_comb begin
    capture = (state == S_IDLE) && i_enable;
    done    = (state == S_BUSY) && (cnt == CNT_W'(LAT - 1));
  end

  // Stage p0: operand capture; held stable for the whole job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (capture) begin
      x_p0 <= iX;
      y_p0 <= iY;
    end
  end

  // Root's final combine is left unregistered so oO is its output register
  karat_node #(.DATA_W(wI), .STAGES(nSTAGE), .REG_OUT(1'b0)) u_root (
    .clk(clk), .rst(rst), .a(x_p0), .b(y_p0), .p(prod)
  );

  // Result register and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oO       <= '0;
      o_finish <= 1'b0;
    end else begin
      o_finish <= done;
      if (done) oO <= prod;
    end
  end
endmodule

// File: tb/tb_karat_mult_recursive.sv
// Directed and streaming checks for karat_mult_recursive, plus a small
// parameter sweep with extra instances sharing the clock and reset.
module tb_karat_mult_recursive;
  localparam int W = 1024;

  logic            clk;
  logic            rst;
  logic            en;
  logic [W-1:0]    x, y;
  logic [2*W-1:0]  o;
  logic            fin;

  logic            en8, en17, en64;
  logic [7:0]      x8, y8;
  logic [15:0]     o8;
  logic            fin8;
  logic [16:0]     x17, y17;
  logic [33:0]     o17;
  logic            fin17;
  logic [63:0]     x64, y64;
  logic [127:0]    o64;
  logic            fin64;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  karat_mult_recursive #(.wI(W), .nSTAGE(5)) u_dut (
    .clk(clk), .rst(rst), .i_enable(en), .iX(x), .iY(y), .oO(o), .o_finish(fin)
  );
  karat_mult_recursive #(.wI(8), .nSTAGE(0)) u_d8 (
    .clk(clk), .rst(rst), .i_enable(en8), .iX(x8), .iY(y8), .oO(o8), .o_finish(fin8)
  );
  karat_mult_recursive #(.wI(17), .nSTAGE(2)) u_d17 (
    .clk(clk), .rst(rst), .i_enable(en17), .iX(x17), .iY(y17), .oO(o17), .o_finish(fin17)
  );
  karat_mult_recursive #(.wI(64), .nSTAGE(3)) u_d64 (
    .clk(clk), .rst(rst), .i_enable(en64), .iX(x64), .iY(y64), .oO(o64), .o_finish(fin64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Starts one job on the main instance and reports result and latency
  // (cycles from the capture edge to the o_finish edge; -1 on timeout).
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] r, output int lat);
    @(negedge clk);
    x = a; y = b; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    lat = -1;
    r   = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (fin) begin
        lat = c;
        r   = o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0; en8 = 1'b0; en17 = 1'b0; en64 = 1'b0;
    x = '0; y = '0; x8 = '0; y8 = '0; x17 = '0; y17 = '0; x64 = '0; y64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o !== '0) begin
      n_bad++; $display("FAIL reset_oO: got low128=%h, want 0", o[127:0]);
    end
    n_vec++;
    if (fin !== 1'b0) begin
      n_bad++; $display("FAIL reset_finish: got %b, want 0", fin);
    end
    n_vec++;
    if ({o8, o17, o64, fin8, fin17, fin64} !== '0) begin
      n_bad++; $display("FAIL reset_sweep: got o8=%h o17=%h o64=%h, want 0", o8, o17, o64);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_identity();
    logic [W-1:0]   b;
    logic [2*W-1:0] r, e;
    int lat;
    b = rnd_w();
    run_job('0, b, r, lat);
    n_vec++;
    if (r !== '0) begin
      n_bad++; $display("FAIL zero_times_y: got low128=%h, want 0", r[127:0]);
    end
    n_vec++;
    if (lat !== 11) begin
      n_bad++; $display("FAIL zero_latency: got %0d, want 11", lat);
    end
    b = rnd_w();
    run_job(W'(1), b, r, lat);
    e = {{W{1'b0}}, b};
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL one_times_y: got low128=%h, want low128=%h", r[127:0], e[127:0]);
    end
    n_vec++;
    if (lat !== 11) begin
      n_bad++; $display("FAIL one_latency: got %0d, want 11", lat);
    end
    run_job(W'(3), W'(5), r, lat);
    e = (2*W)'(15);
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL three_times_five: got low128=%h, want 0f", r[127:0]);
    end
    // 0xFFFFFFFF * 0x10001 = 0xFFFF_FFFF_FFFF_0001 is wrong; hand value below
    run_job(W'(32'hFFFF_FFFF), W'(32'h0001_0001), r, lat);
    e = (2*W)'(64'h0001_0000_FFFE_FFFF);
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL ffffffff_times_10001: got low128=%h, want low128=%h", r[127:0], e[127:0]);
    end
  endtask

  task automatic test_carries();
    logic [W-1:0]   a;
    logic [2*W-1:0] r, e;
    int lat;
    a = '1;
    e = '0;
    for (int i = W + 1; i < 2 * W; i++) e[i] = 1'b1;
    e[0] = 1'b1;
    run_job(a, a, r, lat);
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL all_ones_square: got low128=%h top128=%h, want low128=%h top128=%h",
                        r[127:0], r[2*W-1 -: 128], e[127:0], e[2*W-1 -: 128]);
    end
    n_vec++;
    if (lat !== 11) begin
      n_bad++; $display("FAIL all_ones_latency: got %0d, want 11", lat);
    end
    a = '0;
    a[W-1] = 1'b1;
    e = '0;
    e[2*W-2] = 1'b1;
    run_job(a, a, r, lat);
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL msb_square: got top128=%h, want top128=%h", r[2*W-1 -: 128], e[2*W-1 -: 128]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] e;
    int prev;
    bit found;
    @(negedge clk);
    x = rnd_w(); y = rnd_w(); e = ref_mul(x, y); en = 1'b1;
    prev = -1;
    for (int j = 0; j < 1000; j++) begin
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (fin) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        n_vec++; n_bad++;
        $display("FAIL stream_timeout: job %0d got no o_finish within 40 cycles, want one", j);
        break;
      end
      n_vec++;
      if (o !== e) begin
        n_bad++; $display("FAIL stream_result: job %0d got low128=%h, want low128=%h", j, o[127:0], e[127:0]);
      end
      if (j > 0) begin
        n_vec++;
        if (cyc - prev !== 12) begin
          n_bad++; $display("FAIL stream_period: job %0d got %0d cycles, want 12", j, cyc - prev);
        end
      end
      prev = cyc;
      if (j == 999) en = 1'b0;
      else begin
        x = rnd_w(); y = rnd_w(); e = ref_mul(x, y);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_drop_enable();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] r, e;
    int lat, pulses;
    a = rnd_w(); b = rnd_w(); e = ref_mul(a, b);
    @(negedge clk);
    x = a; y = b; en = 1'b1;
    @(posedge clk);
    #1 x = rnd_w(); y = rnd_w();
    lat = -1; r = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) en = 1'b0;
      if (fin) begin
        lat = c; r = o;
        break;
      end
    end
    n_vec++;
    if (r !== e) begin
      n_bad++; $display("FAIL drop_en_result: got low128=%h, want low128=%h", r[127:0], e[127:0]);
    end
    n_vec++;
    if (lat !== 11) begin
      n_bad++; $display("FAIL drop_en_latency: got %0d, want 11", lat);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (fin) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL drop_en_no_recapture: got %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_reset_midjob();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] r, e;
    int lat, pulses;
    a = rnd_w() | W'(1); b = rnd_w() | W'(1);
    run_job(a, b, r, lat);
    @(negedge clk);
    x = rnd_w(); y = rnd_w(); en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (o !== '0) begin
      n_bad++; $display("FAIL midjob_reset_oO: got low128=%h, want 0", o[127:0]);
    end
    n_vec++;
    if (fin !== 1'b0) begin
      n_bad++; $display("FAIL midjob_reset_finish: got %b, want 0", fin);
    end
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (fin) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (fin) pulses++;
    end
    n_vec++;
    if (pulses !== 0 || o !== '0) begin
      n_bad++; $display("FAIL midjob_abandoned: got %0d pulses low128=%h, want 0 pulses and 0", pulses, o[127:0]);
    end
    a = rnd_w(); b = rnd_w(); e = ref_mul(a, b);
    run_job(a, b, r, lat);
    n_vec++;
    if (r !== e || lat !== 11) begin
      n_bad++; $display("FAIL after_reset_job: got low128=%h lat=%0d, want low128=%h lat=11",
                        r[127:0], lat, e[127:0]);
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0]  e8,  r8;
    logic [33:0]  e17, r17;
    logic [127:0] e64, r64;
    int l8, l17, l64;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        x8 = '1; y8 = '1; x17 = '1; y17 = '1; x64 = '1; y64 = '1;
      end else begin
        x8 = 8'($urandom); y8 = 8'($urandom);
        x17 = 17'($urandom); y17 = 17'($urandom);
        x64 = {$urandom, $urandom}; y64 = {$urandom, $urandom};
      end
      e8  = {8'b0, x8} * {8'b0, y8};
      e17 = {17'b0, x17} * {17'b0, y17};
      e64 = {64'b0, x64} * {64'b0, y64};
      en8 = 1'b1; en17 = 1'b1; en64 = 1'b1;
      @(posedge clk);
      #1 begin en8 = 1'b0; en17 = 1'b0; en64 = 1'b0; end
      l8 = -1; l17 = -1; l64 = -1; r8 = '0; r17 = '0; r64 = '0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (fin8  && l8  < 0) begin l8  = c; r8  = o8;  end
        if (fin17 && l17 < 0) begin l17 = c; r17 = o17; end
        if (fin64 && l64 < 0) begin l64 = c; r64 = o64; end
      end
      n_vec++;
      if (r8 !== e8 || l8 !== 1) begin
        n_bad++; $display("FAIL sweep_8_0: got %h lat=%0d, want %h lat=1", r8, l8, e8);
      end
      n_vec++;
      if (r17 !== e17 || l17 !== 5) begin
        n_bad++; $display("FAIL sweep_17_2: got %h lat=%0d, want %h lat=5", r17, l17, e17);
      end
      n_vec++;
      if (r64 !== e64 || l64 !== 7) begin
        n_bad++; $display("FAIL sweep_64_3: got %h lat=%0d, want %h lat=7", r64, l64, e64);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_identity();
    test_carries();
    test_drop_enable();
    test_reset_midjob();
    test_back_to_back();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
